lsu_rv64: RTL and testbench
===========================

# lsu_rv64

Load/store unit for the multicycle RV64 datapath. It sits between the ALU-output/B registers and the 64-bit data memory, and feeds the MDR. It supports byte, half, word and doubleword accesses: it extracts the addressed lane and sign- or zero-extends it on loads, and does read-modify-write merging for sub-doubleword stores. A start/busy/done handshake lets the control unit's FSM stall in a single wait state. Misaligned and illegal requests are flagged without touching memory.

## Interface
- MEM_RD_LAT, 1: cycles from a stable `mem_raddress` to valid `mem_rdata` (≥1).
- clock  in  1  system clock; one clock domain; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width code: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- addr  in  64  byte address (ALU-out register).
- store_data  in  64  store source (B register); low bytes used.
- load_data  out  64  extended load result, to MDR.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  valid with `done`; 1 = request rejected.
- mem_raddress  out  64  doubleword-aligned read address (`addr & ~7`).
- mem_waddress  out  64  equal to `mem_raddress`.
- mem_wdata  out  64  merged write data.
- mem_wr  out  1  memory write enable.
- mem_rdata  in  64  memory read data.

## Operation
- On `start` in IDLE, the block latches `addr`, `store_data`, `funct3` and `is_store`. `start` in any other state is ignored.
- Size: 1/2/4/8 bytes from `funct3[1:0]`. Offset: `off = addr[2:0]`.
- Misaligned (`off` not a multiple of the size) or illegal (load 111; store with `funct3[2]`=1) goes to DONE with `misaligned`=1. No memory access; `load_data` is unchanged.
- States:
  - IDLE → READ for loads and sub-doubleword stores.
  - IDLE → WRITE for sd.
  - IDLE → DONE on error.
  - READ → DONE for loads, WRITE for stores.
  - WRITE → DONE.
  - DONE → IDLE.
- READ lasts MEM_RD_LAT+1 cycles, counted by an internal counter. `mem_rdata` is sampled at the edge that ends READ.
- Load result: `lane = rdata >> 8*off`, truncated to the access size. It is sign-extended for b/h/w/d and zero-extended for bu/hu/wu. It is registered into `load_data` at the end of READ.
- Store merge: `mask` = size-byte mask shifted by `off`. `wdata = (rdata & ~mask) | ((store_data << 8*off) & mask)`, registered at the end of READ. For sd, `wdata = store_data`.
- `mem_wr = (state == WRITE) && !reset`. It is high for exactly one cycle per store.
- Address outputs hold the latched aligned address in all non-IDLE states.

## Timing
- Reset values: state IDLE, `load_data`=0, `mem_wdata`=0, address regs 0, counter 0. `busy`, `done`, `misaligned` and `mem_wr` are all 0.
- Start sampled at the end of cycle N. Results, with MEM_RD_LAT=1:
  - Load: READ in N+1..N+2, `done` at N+3; `load_data` is valid from N+3.
  - Sub-doubleword store: READ in N+1..N+2, `mem_wr` at N+3, `done` at N+4.
  - sd: `mem_wr` at N+1, `done` at N+2.
  - Error: `done` + `misaligned` at N+1.
- In general, a load completes in MEM_RD_LAT+2 cycles after acceptance.
- `busy` is high from N+1 through the DONE cycle inclusive. The next `start` is accepted no earlier than the cycle after DONE.
- `load_data` holds its value until the next successful load completes.
- Reset mid-operation: the state is IDLE at the next edge. A write is never issued in a cycle where `reset` is high. No `done` pulse is produced for the aborted request.
- Address arithmetic is 64-bit unsigned. The low 3 bits are masked and there is no wrap handling.

## Structure
- Package `lsu_pkg`:
  - state enum (IDLE, READ, WRITE, DONE);
  - funct3 width constants;
  - function `byte_mask(size, off)`.
- Sub-module `lsu_align`: purely combinational lane extraction, extension and store merge. The top level holds only the FSM, the counter and the registers.

## Test plan
Memory at 0x40 is preloaded with 0x8877_6655_4433_2211.
- lb at 0x47 → `load_data` 0xFFFF_FFFF_FFFF_FF88, `done` at N+3, `mem_wr` never asserted.
- lhu at 0x46 → 0x0000_0000_0000_8877; lw at 0x44 → 0xFFFF_FFFF_8877_6655; ld at 0x40 → the full word.
- sb at 0x41 with `store_data` 0x…AB → `mem_wr` at N+3 only, address 0x40, data 0x8877_6655_4433_AB11, `done` at N+4.
- sd at 0x48 with 0x0123_4567_89AB_CDEF → `mem_wr` at N+1 with that data, no READ state, `done` at N+2.
- lw at 0x42 and sh at 0x43 → `done`+`misaligned` at N+1, no `mem_wr`, `load_data` unchanged. A load with funct3 111 → the same response.
- `reset` pulsed during READ of an sb → no `mem_wr`, no `done`, `busy`=0 the next cycle. A `start` issued while busy is ignored and does not alter the latched request.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV64 load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsuState_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte-lane enables for an access of 2**size bytes starting at byte off.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane extraction / extension for loads and read-modify-write merge for stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [63:0] storeData,
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  output logic [63:0] loadValue,
  output logic [63:0] mergedData
);

  logic [63:0] lane;
  logic [63:0] shiftedData;
  logic [63:0] bitMask;
  logic [7:0]  laneMask;

  always_comb begin
    lane = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    loadValue = {{56{lane[7]}}, lane[7:0]};
      F3_H:    loadValue = {{48{lane[15]}}, lane[15:0]};
      F3_W:    loadValue = {{32{lane[31]}}, lane[31:0]};
      F3_BU:   loadValue = {56'd0, lane[7:0]};
      F3_HU:   loadValue = {48'd0, lane[15:0]};
      F3_WU:   loadValue = {32'd0, lane[31:0]};
      default: loadValue = lane;
    endcase
  end

  // Store data is placed at its byte offset and only the enabled lanes replace memory bytes.
  always_comb begin
    laneMask = byte_mask(funct3[1:0], off);
    bitMask  = '0;
    for (int i = 0; i < 8; i++) begin
      bitMask[8*i +: 8] = {8{laneMask[i]}};
    end
    shiftedData = storeData << {off, 3'b000};
    mergedData  = (rdata & ~bitMask) | (shiftedData & bitMask);
  end

endmodule

// File: rtl/lsu_rv64.sv
// Load/store unit for the multicycle RV64 datapath: FSM, read-latency counter and result registers.
module lsu_rv64
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  output logic [63:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [63:0] mem_raddress,
  output logic [63:0] mem_waddress,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata
);

  // Handshake: a request is taken when start is high while busy is low; busy then stays high
  // through the single-cycle done pulse, and start seen while busy is dropped without effect.

  localparam int CNT_W = (MEM_RD_LAT < 2) ? 1 : $clog2(MEM_RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LAT);

  lsuState_e        state, nextState;
  logic [CNT_W-1:0] rdCnt;
  logic             reqStore;
  logic             reqErr;
  logic [2:0]       reqFunct3;
  logic [2:0]       reqOff;
  logic [63:0]      reqData;
  logic [63:0]      addrReg;
  logic             accept;
  logic             reqIllegal;
  logic             reqMisaligned;
  logic             newErr;
  logic             readLast;
  logic [63:0]      alignLoad;
  logic [63:0]      alignMerge;

  always_comb begin
    accept     = (state == IDLE) && start;
    reqIllegal = is_store ? funct3[2] : (funct3 == 3'b111);
    case (funct3[1:0])
      2'd0:    reqMisaligned = 1'b0;
      2'd1:    reqMisaligned = addr[0];
      2'd2:    reqMisaligned = |addr[1:0];
      default: reqMisaligned = |addr[2:0];
    endcase
    newErr   = reqIllegal | reqMisaligned;
    readLast = (state == READ) && (rdCnt == CNT_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (newErr)                           nextState = DONE;
          else if (is_store && funct3 == F3_D)  nextState = WRITE;
          else                                  nextState = READ;
        end
      end
      READ:    if (readLast) nextState = reqStore ? WRITE : DONE;
      WRITE:   nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    misaligned = done && reqErr;
    mem_wr     = (state == WRITE) && !reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdCnt     <= '0;
      reqStore  <= 1'b0;
      reqErr    <= 1'b0;
      reqFunct3 <= '0;
      reqOff    <= '0;
      reqData   <= '0;
      addrReg   <= '0;
      load_data <= '0;
      mem_wdata <= '0;
    end else begin
      rdCnt <= (state == READ && !readLast) ? rdCnt + 1'b1 : '0;
      if (accept) begin
        reqStore  <= is_store;
        reqErr    <= newErr;
        reqFunct3 <= funct3;
        reqOff    <= addr[2:0];
        reqData   <= store_data;
        addrReg   <= {addr[63:3], 3'b000};
        // A full doubleword store skips the read, so its data is final right away.
        if (is_store && funct3 == F3_D && !newErr) mem_wdata <= store_data;
      end
      if (readLast) begin
        if (reqStore) mem_wdata <= alignMerge;
        else          load_data <= alignLoad;
      end
    end
  end

  assign mem_raddress = addrReg;
  assign mem_waddress = addrReg;

  lsu_align uAlign (
    .rdata      (mem_rdata),
    .storeData  (reqData),
    .funct3     (reqFunct3),
    .off        (reqOff),
    .loadValue  (alignLoad),
    .mergedData (alignMerge)
  );

endmodule

// File: tb/tb_lsu_rv64.sv
// Scoreboard bench for lsu_rv64 with a byte-level memory reference model.
module tb_lsu_rv64;

  localparam int LAT = 1;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic [63:0] load_data;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [63:0] mem_raddress;
  logic [63:0] mem_waddress;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic [63:0] mem_rdata;

  lsu_rv64 #(.MEM_RD_LAT(LAT)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .is_store     (is_store),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .load_data    (load_data),
    .busy         (busy),
    .done         (done),
    .misaligned   (misaligned),
    .mem_raddress (mem_raddress),
    .mem_waddress (mem_waddress),
    .mem_wdata    (mem_wdata),
    .mem_wr       (mem_wr),
    .mem_rdata    (mem_rdata)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- memory seen by the DUT (1-cycle read latency) ----------------
  logic [63:0] ram [0:31];
  logic [63:0] model_mem [0:31];
  logic [63:0] rdPipe;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ram[i] <= model_mem[i];
    end else if (mem_wr) begin
      ram[mem_waddress[7:3]] <= mem_wdata;
    end
    rdPipe <= ram[mem_raddress[7:3]];
  end
  assign mem_rdata = rdPipe;

  // ---------------- scoreboard state ----------------
  logic [72:0]  exp_q[$];   // {misaligned, load_data, done latency}
  logic [135:0] wr_q[$];    // {address, data, write latency}
  logic [63:0]  expLoad;
  int           acceptCyc;
  int           asserts = 0;
  int           fails = 0;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] modelLoad(input logic [63:0] dw, input logic [2:0] f3, input int off);
    int n;
    logic [63:0] v;
    logic [63:0] keep;
    n = 1 << f3[1:0];
    v = dw >> (8 * off);
    if (n < 8) begin
      keep = (64'd1 << (8 * n)) - 64'd1;
      v = v & keep;
      if (!f3[2] && v[8*n-1]) v = v | ~keep;
    end
    return v;
  endfunction

  function automatic logic [63:0] modelStore(input logic [63:0] dw, input logic [63:0] sd,
                                             input logic [2:0] f3, input int off);
    int n;
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) dw[8*(off+i) +: 8] = sd[8*i +: 8];
    return dw;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      asserts++;
      fails++;
      $display("FAIL timeout: busy still high after %0d cycles", n);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] sd, input bit poke);
    int n, off, idx, doneLat, wrLat;
    bit err;
    logic [63:0] newDw;
    n   = 1 << f3[1:0];
    off = int'(a[2:0]);
    idx = int'(a[7:3]);
    err = (off % n != 0) || (!st && f3 == 3'd7) || (st && f3 >= 3'd4);
    if (err)             begin doneLat = 1;       wrLat = 0; end
    else if (!st)        begin doneLat = LAT + 2; wrLat = 0; end
    else if (n == 8)     begin doneLat = 2;       wrLat = 1; end
    else                 begin doneLat = LAT + 3; wrLat = LAT + 2; end
    if (!err && st) begin
      newDw = modelStore(model_mem[idx], sd, f3, off);
      model_mem[idx] = newDw;
      wr_q.push_back({a & ~64'd7, newDw, 8'(wrLat)});
    end
    if (!err && !st) expLoad = modelLoad(model_mem[idx], f3, off);
    exp_q.push_back({err, expLoad, 8'(doneLat)});

    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    @(posedge clock);
    #1;
    acceptCyc = cyc - 1;
    start = 1'b0;
    addr = {$urandom, $urandom};
    store_data = {$urandom, $urandom};
    if (poke) begin
      @(negedge clock);
      start = 1'b1;
      is_store = 1'($urandom_range(0, 1));
      funct3 = 3'($urandom_range(0, 7));
      addr = 64'($urandom_range(0, 255));
      store_data = {$urandom, $urandom};
      @(negedge clock);
      start = 1'b0;
    end
    waitIdle();
  endtask

  // Abort a byte store in its READ phase; nothing may reach memory or the done output.
  task automatic resetMid(input logic [63:0] a, input logic [63:0] sd);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = a; store_data = sd;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    checkVal("rst_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    checkVal("rst_busy_after", 64'(busy), 64'd0);
    checkVal("rst_load_data", load_data, 64'd0);
    reset = 1'b0;
    expLoad = '0;
    repeat (6) @(negedge clock);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [135:0] w;
    logic [72:0]  d;
    if (reset && mem_wr) begin
      asserts++;
      fails++;
      $display("FAIL wr_in_reset: mem_wr=1 while reset is high");
    end
    if (mem_wr) begin
      if (wr_q.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL unexpected_wr: addr=%h data=%h", mem_waddress, mem_wdata);
      end else begin
        w = wr_q.pop_front();
        checkVal("wr_addr", mem_waddress, w[135:72]);
        checkVal("rd_addr", mem_raddress, w[135:72]);
        checkVal("wr_data", mem_wdata, w[71:8]);
        checkVal("wr_latency", 64'(cyc - acceptCyc), 64'(w[7:0]));
      end
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL unexpected_done: misaligned=%b load_data=%h", misaligned, load_data);
      end else begin
        d = exp_q.pop_front();
        checkVal("done_busy", 64'(busy), 64'd1);
        checkVal("misaligned", 64'(misaligned), 64'(d[72]));
        checkVal("load_data", load_data, d[71:8]);
        checkVal("done_latency", 64'(cyc - acceptCyc), 64'(d[7:0]));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] a;
    logic [2:0]  f3;
    int          sz;
    for (int i = 0; i < 32; i++) model_mem[i] = {$urandom, $urandom};
    model_mem[8] = 64'h8877_6655_4433_2211;
    expLoad = '0;
    acceptCyc = 0;
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    repeat (3) @(negedge clock);
    checkVal("rst_busy", 64'(busy), 64'd0);
    checkVal("rst_done", 64'(done), 64'd0);
    checkVal("rst_misaligned", 64'(misaligned), 64'd0);
    checkVal("rst_mem_wr", 64'(mem_wr), 64'd0);
    checkVal("rst_load_data", load_data, 64'd0);
    checkVal("rst_mem_raddress", mem_raddress, 64'd0);
    checkVal("rst_mem_wdata", mem_wdata, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    issue(1'b0, 3'b000, 64'h47, 64'd0, 1'b0);                    // lb
    issue(1'b0, 3'b101, 64'h46, 64'd0, 1'b0);                    // lhu
    issue(1'b0, 3'b010, 64'h44, 64'd0, 1'b0);                    // lw
    issue(1'b0, 3'b011, 64'h40, 64'd0, 1'b0);                    // ld
    issue(1'b1, 3'b000, 64'h41, 64'hDEAD_BEEF_0000_00AB, 1'b0);  // sb
    issue(1'b1, 3'b011, 64'h48, 64'h0123_4567_89AB_CDEF, 1'b0);  // sd
    issue(1'b0, 3'b010, 64'h42, 64'd0, 1'b0);                    // misaligned lw
    issue(1'b1, 3'b001, 64'h43, 64'h1234, 1'b0);                 // misaligned sh
    issue(1'b0, 3'b111, 64'h40, 64'd0, 1'b0);                    // illegal load
    issue(1'b1, 3'b100, 64'h40, 64'h55, 1'b0);                   // illegal store
    issue(1'b0, 3'b011, 64'h48, 64'd0, 1'b1);                    // ld with a start poked while busy
    issue(1'b1, 3'b001, 64'h44, 64'hFFFF_CAFE, 1'b1);            // sh with a start poked while busy
    issue(1'b1, 3'b011, 64'h50, 64'h1111_2222_3333_4444, 1'b1);  // sd with a start poked while busy
    resetMid(64'h41, 64'h77);
    issue(1'b0, 3'b011, 64'h40, 64'd0, 1'b0);                    // memory untouched by aborted sb

    for (int k = 0; k < 300; k++) begin
      f3 = 3'($urandom_range(0, 7));
      sz = 1 << f3[1:0];
      a  = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) a = a & ~64'(sz - 1);
      issue(1'($urandom_range(0, 1)), f3, a, {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
    end

    repeat (4) @(negedge clock);
    checkVal("exp_q_drained", 64'(exp_q.size()), 64'd0);
    checkVal("wr_q_drained", 64'(wr_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
